// File: rtl/tensor_core_pkg.sv
// Shared opcodes, field widths and sequencer state encoding for the tensor core
// instruction path.
package tensor_core_pkg;

    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] OPC_HALT = 4'hF;
    localparam logic [OPCODE_WIDTH-1:0] OPC_JUMP = 4'hE;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/tensor_core_instruction_ram.sv
// Program store: one write port, one registered read port. A read and a write
// to the same address in the same cycle return the old word.
module tensor_core_instruction_ram #(
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 1024,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                   clock_in,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [INSTR_WIDTH-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [INSTR_WIDTH-1:0] rd_data
);

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tensor_core_instruction_sequencer.sv
// Fetches program words, executes HALT/JUMP locally and issues the rest over
// valid/ready. Optional issue counter: define TENSOR_CORE_SEQ_ISSUE_COUNT_EN.
module tensor_core_instruction_sequencer
    import tensor_core_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 1024,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   load_valid_in,
    input  logic [ADDR_WIDTH-1:0]  load_addr_in,
    input  logic [INSTR_WIDTH-1:0] load_data_in,
    input  logic                   start_in,
    input  logic [ADDR_WIDTH-1:0]  start_addr_in,
    input  logic                   abort_in,
    input  logic                   instr_ready_in,
    output logic                   instr_valid_out,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   overrun_out
`ifdef TENSOR_CORE_SEQ_ISSUE_COUNT_EN
    ,
    output logic [31:0]            issued_count_out
`endif
);

    if (ADDR_WIDTH > INSTR_WIDTH - OPCODE_WIDTH) begin : g_addr_width_check
        $error("ADDR_WIDTH does not fit below the opcode field of the instruction word");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    seq_state_t               state, state_next;
    logic [ADDR_WIDTH-1:0]    pc_next;
    logic [INSTR_WIDTH-1:0]   instr_next;
    logic [INSTR_WIDTH-1:0]   fetch_word;
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic                     valid_next;
    logic                     overrun_next;
    logic                     idle_or_done;
    logic                     start_go;
    logic                     handshake;

    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign start_go     = start_in && idle_or_done && !abort_in;
    assign handshake    = instr_valid_out && instr_ready_in;
    assign opcode       = fetch_word[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign busy_out     = !idle_or_done;
    assign done_out     = (state == DONE);

    tensor_core_instruction_ram #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_ram (
        .clock_in (clock_in),
        .wr_en    (load_valid_in && idle_or_done),
        .wr_addr  (load_addr_in),
        .wr_data  (load_data_in),
        .rd_en    (state == FETCH),
        .rd_addr  (pc_out),
        .rd_data  (fetch_word)
    );

    always_comb begin
        state_next   = state;
        pc_next      = pc_out;
        instr_next   = instruction_out;
        valid_next   = instr_valid_out;
        overrun_next = overrun_out;
        if (abort_in) begin
            state_next   = IDLE;
            valid_next   = 1'b0;
            overrun_next = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_in) begin
                        pc_next      = start_addr_in;
                        overrun_next = 1'b0;
                        state_next   = FETCH;
                    end
                end
                FETCH: state_next = DECODE;
                DECODE: begin
                    if (opcode == OPC_HALT) begin
                        state_next = DONE;
                    end else if (opcode == OPC_JUMP) begin
                        pc_next    = fetch_word[ADDR_WIDTH-1:0];
                        state_next = FETCH;
                    end else begin
                        instr_next = fetch_word;
                        valid_next = 1'b1;
                        state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready_in) begin
                        valid_next = 1'b0;
                        // Running past the last word is terminal, never a wrap.
                        if (pc_out == LAST_ADDR) begin
                            overrun_next = 1'b1;
                            state_next   = DONE;
                        end else begin
                            pc_next    = pc_out + 1'b1;
                            state_next = FETCH;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state           <= IDLE;
            pc_out          <= '0;
            instruction_out <= '0;
            instr_valid_out <= 1'b0;
            overrun_out     <= 1'b0;
        end else begin
            state           <= state_next;
            pc_out          <= pc_next;
            instruction_out <= instr_next;
            instr_valid_out <= valid_next;
            overrun_out     <= overrun_next;
        end
    end

`ifdef TENSOR_CORE_SEQ_ISSUE_COUNT_EN
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            issued_count_out <= '0;
        end else if (start_go) begin
            issued_count_out <= '0;
        end else if (handshake && (issued_count_out != 32'hFFFF_FFFF)) begin
            issued_count_out <= issued_count_out + 32'd1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = start_go ^ handshake;
`endif

endmodule

// File: tb/tb_tensor_core_instruction_sequencer.sv
// Directed bench for the instruction sequencer with a program-level reference
// interpreter and a per-cycle compare process on the issue interface.
module tb_tensor_core_instruction_sequencer;

    localparam int INSTR_WIDTH = 16;
    localparam int DEPTH       = 8;
    localparam int ADDR_WIDTH  = 3;

    logic                   clock_in = 1'b0;
    logic                   reset_in = 1'b0;
    logic                   load_valid_in = 1'b0;
    logic [ADDR_WIDTH-1:0]  load_addr_in = '0;
    logic [INSTR_WIDTH-1:0] load_data_in = '0;
    logic                   start_in = 1'b0;
    logic [ADDR_WIDTH-1:0]  start_addr_in = '0;
    logic                   abort_in = 1'b0;
    logic                   instr_ready_in = 1'b0;
    logic                   instr_valid_out;
    logic [INSTR_WIDTH-1:0] instruction_out;
    logic [ADDR_WIDTH-1:0]  pc_out;
    logic                   busy_out;
    logic                   done_out;
    logic                   overrun_out;
`ifdef TENSOR_CORE_SEQ_ISSUE_COUNT_EN
    logic [31:0]            issued_count_out;
`endif

    always #5 clock_in = ~clock_in;

    tensor_core_instruction_sequencer #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .load_valid_in   (load_valid_in),
        .load_addr_in    (load_addr_in),
        .load_data_in    (load_data_in),
        .start_in        (start_in),
        .start_addr_in   (start_addr_in),
        .abort_in        (abort_in),
        .instr_ready_in  (instr_ready_in),
        .instr_valid_out (instr_valid_out),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .overrun_out     (overrun_out)
`ifdef TENSOR_CORE_SEQ_ISSUE_COUNT_EN
        ,
        .issued_count_out (issued_count_out)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int hs_count = 0;
    int lat;

    logic [INSTR_WIDTH-1:0] model_mem [DEPTH];
    logic [INSTR_WIDTH-1:0] exp_q [$];
    logic [ADDR_WIDTH-1:0]  exp_pc;
    logic                   exp_over;

    logic                   prev_hold  = 1'b0;
    logic                   prev_abort = 1'b0;
    logic [INSTR_WIDTH-1:0] prev_word  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Program-level interpreter: what a run from addr must issue and where it ends.
    task automatic model_run(input logic [ADDR_WIDTH-1:0] addr);
        int pc;
        logic [INSTR_WIDTH-1:0] w;
        pc = int'(addr);
        exp_q.delete();
        exp_over = 1'b0;
        for (int step = 0; step < 64; step++) begin
            w = model_mem[pc];
            if (w[15:12] == 4'hF) break;
            if (w[15:12] == 4'hE) begin
                pc = int'(w[ADDR_WIDTH-1:0]);
            end else begin
                exp_q.push_back(w);
                if (pc == DEPTH - 1) begin
                    exp_over = 1'b1;
                    break;
                end
                pc++;
            end
        end
        exp_pc = ADDR_WIDTH'(pc);
    endtask

    always @(negedge clock_in) begin
        if (reset_in) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && !prev_abort) begin
                check("hold_valid", 32'(instr_valid_out), 32'd1);
                check("hold_word", 32'(instruction_out), 32'(prev_word));
            end
            if (instr_valid_out && instr_ready_in) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_issue: got %0h, expected no issue", instruction_out);
                end else begin
                    check("issue_word", 32'(instruction_out), 32'(exp_q.pop_front()));
                end
            end
            prev_hold  = instr_valid_out && !instr_ready_in;
            prev_word  = instruction_out;
            prev_abort = abort_in;
        end
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic load(input logic [ADDR_WIDTH-1:0] a, input logic [INSTR_WIDTH-1:0] d, input bit upd);
        load_valid_in = 1'b1;
        load_addr_in  = a;
        load_data_in  = d;
        tick();
        load_valid_in = 1'b0;
        if (upd) model_mem[a] = d;
    endtask

    task automatic start_run(input logic [ADDR_WIDTH-1:0] a);
        model_run(a);
        hs_count      = 0;
        start_in      = 1'b1;
        start_addr_in = a;
        tick();
        start_in      = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid_out && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_out && n < 300) begin
            tick();
            n++;
        end
        check("done_reached", 32'(done_out), 32'd1);
        check("end_pc", 32'(pc_out), 32'(exp_pc));
        check("end_overrun", 32'(overrun_out), 32'(exp_over));
        check("all_issued", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
        check("quiet_after_done", 32'(instr_valid_out), 32'd0);
        check("busy_after_done", 32'(busy_out), 32'd0);
    endtask

    initial begin
        #1 reset_in = 1'b1;
        repeat (2) tick();
        check("rst_valid", 32'(instr_valid_out), 32'd0);
        check("rst_instr", 32'(instruction_out), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_overrun", 32'(overrun_out), 32'd0);
        reset_in = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) load(ADDR_WIDTH'(i), 16'hF000, 1'b1);
        load(3'd0, 16'h1001, 1'b1);
        load(3'd1, 16'h1002, 1'b1);
        load(3'd2, 16'hF000, 1'b1);

        // Straight-line program, ready always high.
        instr_ready_in = 1'b1;
        start_run(3'd0);
        wait_valid(lat);
        check("t1_latency", 32'(lat), 32'd2);
        check("t1_first_word", 32'(instruction_out), 32'h1001);
        wait_done();
        check("t1_handshakes", 32'(hs_count), 32'd2);
        check("t1_pc", 32'(pc_out), 32'd2);

        // Back-pressure on the first issue.
        instr_ready_in = 1'b0;
        start_run(3'd0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_valid", 32'(instr_valid_out), 32'd1);
            check("t2_stall_word", 32'(instruction_out), 32'h1001);
        end
        instr_ready_in = 1'b1;
        wait_done();
        check("t2_handshakes", 32'(hs_count), 32'd2);

        // JUMP over a gap; the jump word itself is never issued.
        load(3'd0, 16'hE005, 1'b1);
        load(3'd5, 16'h2222, 1'b1);
        load(3'd6, 16'hF000, 1'b1);
        start_run(3'd0);
        wait_done();
        check("t3_handshakes", 32'(hs_count), 32'd1);
        check("t3_pc", 32'(pc_out), 32'd6);

        // Issue from the last address runs off the end.
        load(3'd7, 16'h3333, 1'b1);
        start_run(3'd7);
        wait_valid(lat);
        check("t4_latency", 32'(lat), 32'd2);
        wait_done();
        check("t4_overrun", 32'(overrun_out), 32'd1);
        check("t4_pc", 32'(pc_out), 32'd7);
        check("t4_handshakes", 32'(hs_count), 32'd1);

        // Abort while an instruction is waiting, then re-run.
        load(3'd0, 16'h1001, 1'b1);
        instr_ready_in = 1'b0;
        start_run(3'd0);
        wait_valid(lat);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        exp_q.delete();
        check("t5_abort_valid", 32'(instr_valid_out), 32'd0);
        check("t5_abort_busy", 32'(busy_out), 32'd0);
        check("t5_abort_done", 32'(done_out), 32'd0);
        check("t5_abort_overrun", 32'(overrun_out), 32'd0);
        check("t5_abort_pc", 32'(pc_out), 32'd0);
        check("t5_abort_no_hs", 32'(hs_count), 32'd0);
        instr_ready_in = 1'b1;
        start_run(3'd0);
        wait_valid(lat);
        check("t5_rerun_first", 32'(instruction_out), 32'h1001);
        wait_done();
        check("t5_handshakes", 32'(hs_count), 32'd2);

        // A load while busy must not reach memory; two runs back to back.
        instr_ready_in = 1'b0;
        start_run(3'd0);
        wait_valid(lat);
        load(3'd1, 16'h7777, 1'b0);
        instr_ready_in = 1'b1;
        wait_done();
        check("t6_run1_handshakes", 32'(hs_count), 32'd2);
`ifdef TENSOR_CORE_SEQ_ISSUE_COUNT_EN
        check("t6_run1_count", issued_count_out, 32'd2);
`endif
        start_run(3'd0);
        wait_done();
        check("t6_run2_handshakes", 32'(hs_count), 32'd2);
`ifdef TENSOR_CORE_SEQ_ISSUE_COUNT_EN
        check("t6_run2_count", issued_count_out, 32'd2);
`endif

        // Load and start in the same DONE cycle: the new word is fetched.
        model_mem[0] = 16'h4444;
        model_run(3'd0);
        hs_count      = 0;
        load_valid_in = 1'b1;
        load_addr_in  = 3'd0;
        load_data_in  = 16'h4444;
        start_in      = 1'b1;
        start_addr_in = 3'd0;
        tick();
        load_valid_in = 1'b0;
        start_in      = 1'b0;
        wait_valid(lat);
        check("t7_new_word", 32'(instruction_out), 32'h4444);
        wait_done();
        check("t7_handshakes", 32'(hs_count), 32'd2);

        // Asynchronous reset in the middle of an issue.
        instr_ready_in = 1'b0;
        start_run(3'd0);
        wait_valid(lat);
        #1 reset_in = 1'b1;
        #1;
        check("t8_async_valid", 32'(instr_valid_out), 32'd0);
        check("t8_async_busy", 32'(busy_out), 32'd0);
        check("t8_async_pc", 32'(pc_out), 32'd0);
        tick();
        reset_in = 1'b0;
        exp_q.delete();
        tick();
        check("t8_after_reset_hs", 32'(hs_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
